// File: rtl/ras_ckpt_predictor_if.sv
// Request/response bundle for the return-address-stack predictor.
// The front end drives the master side; the predictor owns the slave side.
interface ras_ckpt_predictor_if #(
  parameter int XLEN  = 64,
  parameter int NCKPT = 4
);
  localparam int IW = (NCKPT > 1) ? $clog2(NCKPT) : 1;

  logic            Flush;
  logic            Push;
  logic [XLEN-1:0] PushAddr;
  logic            Pop;
  logic            CkptSave;
  logic            CkptRestore;
  logic [IW-1:0]   CkptIdx;
  logic [XLEN-1:0] TopAddr;
  logic            TopValid;
  logic            Full;
  logic            Underflow;

  modport master (
    output Flush, Push, PushAddr, Pop, CkptSave, CkptRestore, CkptIdx,
    input  TopAddr, TopValid, Full, Underflow
  );
  modport slave (
    input  Flush, Push, PushAddr, Pop, CkptSave, CkptRestore, CkptIdx,
    output TopAddr, TopValid, Full, Underflow
  );
endinterface

// File: rtl/ras_ckpt_predictor.sv
// Circular return-address stack with optional checkpoint/restore for branch recovery.
// Define RAS_CKPT_EN to build the checkpoint slots; without it only Flush recovers.
module ras_ckpt_predictor #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 16,
  parameter int NCKPT = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  ras_ckpt_predictor_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] top;
  } ckpt_t;

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CW-1:0]   count_q, count_d;
  logic            underflow_q, underflow_d;
  logic            full;
  logic            we;
  logic [PW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic            restore_en;
  ckpt_t           rd_ckpt;

  assign full    = (count_q == CW'(DEPTH));
  assign ptr_inc = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - 1'b1;

  assign bus.TopAddr   = mem_q[ptr_q];
  assign bus.TopValid  = (count_q != '0);
  assign bus.Full      = full;
  assign bus.Underflow = underflow_q;

`ifdef RAS_CKPT_EN
  ckpt_t ckpt_q [NCKPT];
  logic  idx_ok;

  // Guards non-power-of-2 slot counts against an out-of-range select.
  assign idx_ok     = (32'(bus.CkptIdx) < NCKPT);
  assign restore_en = bus.CkptRestore && idx_ok;
  assign rd_ckpt    = idx_ok ? ckpt_q[bus.CkptIdx] : '0;

  // Restore reads the old slot combinationally, so a same-slot save overwrites it afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCKPT; i++) ckpt_q[i] <= '0;
    end else if (bus.CkptSave && idx_ok) begin
      ckpt_q[bus.CkptIdx] <= '{ptr: ptr_q, count: count_q, top: mem_q[ptr_q]};
    end
  end
`else
  logic unused_ckpt;
  assign unused_ckpt = ^{bus.CkptSave, bus.CkptRestore, bus.CkptIdx};
  assign restore_en  = 1'b0;
  assign rd_ckpt     = '0;
`endif

  always_comb begin
    ptr_d       = ptr_q;
    count_d     = count_q;
    underflow_d = 1'b0;
    we          = 1'b0;
    waddr       = ptr_q;
    wdata       = bus.PushAddr;
    if (bus.Flush) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (restore_en) begin
      // Writing the saved top back repairs an entry a wrong-path push overwrote.
      ptr_d   = rd_ckpt.ptr;
      count_d = rd_ckpt.count;
      we      = 1'b1;
      waddr   = rd_ckpt.ptr;
      wdata   = rd_ckpt.top;
    end else if (bus.Push && bus.Pop) begin
      we      = 1'b1;
      count_d = (count_q == '0) ? CW'(1) : count_q;
    end else if (bus.Push) begin
      ptr_d   = ptr_inc;
      we      = 1'b1;
      waddr   = ptr_inc;
      count_d = full ? count_q : count_q + 1'b1;
    end else if (bus.Pop) begin
      if (count_q != '0) begin
        ptr_d   = ptr_dec;
        count_d = count_q - 1'b1;
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
      if (we) mem_q[waddr] <= wdata;
    end
  end
endmodule
